// File: rtl/kmi_transmit_p.sv
// kmi_transmit_p
// Host-to-device transmitter for a PS/2 style keyboard/mouse interface.
// The host inhibits the clock line, places a start bit, then lets the device
// clock out the payload (LSB first), optional parity and stop bit. The
// device acknowledges the frame by pulling the data line low on the final
// clock. A watchdog aborts the frame if the device stops clocking.
//
// Ports:
//   ref_clk    - internal clock, all state updates on its rising edge
//   nreset     - asynchronous active-low reset
//   transmit   - start request, accepted only while idle
//   data_in    - payload, captured on the accepted request
//   clk_in     - device clock line readback (asynchronous)
//   serial_in  - data line readback (asynchronous), carries the device ACK
//   serial_out - value driven onto the data line
//   ndata_en   - active-low data line drive enable
//   nclk_en    - active-low clock line pull-down (inhibit)
//   busy       - frame in progress
//   tx_done    - one-cycle pulse on an acknowledged frame
//   tx_err     - one-cycle pulse on a failed frame
//   err_code   - last failure cause: 00 none, 01 no ACK, 10 timeout
module kmi_transmit_p #(
  parameter int DATA_W         = 8,
  parameter int PARITY_MODE    = 1,
  parameter int INHIBIT_CYCLES = 100,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              ref_clk,
  input  logic              nreset,
  input  logic              transmit,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clk_in,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              ndata_en,
  output logic              nclk_en,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_err,
  output logic [1:0]        err_code
);

  localparam int PAR_EN   = (PARITY_MODE != 0) ? 1 : 0;
  localparam int STOP_IDX = DATA_W + PAR_EN;
  localparam int BIT_W    = $clog2(DATA_W + 3);
  localparam int INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK} state_e;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [INH_W-1:0]       inhCnt_q, inhCnt_d;
  logic [TMO_W-1:0]       tmoCnt_q, tmoCnt_d;
  logic [BIT_W-1:0]       bitCnt_q, bitCnt_d;
  logic [1:0]             errCode_q, errCode_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
  logic                   clkPrev_q;
  logic                   fe;
  logic                   inhLast;
  logic                   parityIn;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false
  // falling edge straight after reset.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], clk_in};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], serial_in};
      clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
    end
  end

  assign fe      = clkPrev_q & ~clkSync_q[SYNC_STAGES-1];
  assign inhLast = (inhCnt_q == INH_W'(INHIBIT_CYCLES - 1));

  // Parity is fixed at capture time; the payload register is then free to
  // shift right so that bit 0 is always the bit on the line.
  assign parityIn = (PARITY_MODE == 1) ? ~(^data_in) : (^data_in);

  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      inhCnt_q  <= '0;
      tmoCnt_q  <= '0;
      bitCnt_q  <= '0;
      errCode_q <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      inhCnt_q  <= inhCnt_d;
      tmoCnt_q  <= tmoCnt_d;
      bitCnt_q  <= bitCnt_d;
      errCode_q <= errCode_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath. In the device-clocked states a falling edge
  // always wins over the watchdog, since it restarts the timeout window.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    inhCnt_d  = inhCnt_q;
    tmoCnt_d  = tmoCnt_q;
    bitCnt_d  = bitCnt_q;
    errCode_d = errCode_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (transmit) begin
          state_d   = INHIBIT;
          shift_d   = data_in;
          parity_d  = parityIn;
          errCode_d = 2'b00;
          inhCnt_d  = '0;
          bitCnt_d  = '0;
        end
      end
      INHIBIT: begin
        if (inhLast) begin
          state_d  = REQ;
          tmoCnt_d = '0;
        end else begin
          inhCnt_d = inhCnt_q + 1'b1;
        end
      end
      REQ, SHIFT, ACK: begin
        if (fe) begin
          tmoCnt_d = '0;
          if (state_q == REQ) begin
            state_d  = SHIFT;
            bitCnt_d = '0;
          end else if (state_q == SHIFT) begin
            shift_d = shift_q >> 1;
            if (bitCnt_q == BIT_W'(STOP_IDX)) begin
              state_d = ACK;
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            if (!dataSync_q[SYNC_STAGES-1]) begin
              done_d = 1'b1;
            end else begin
              err_d     = 1'b1;
              errCode_d = 2'b01;
            end
          end
        end else if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          tmoCnt_d  = '0;
          err_d     = 1'b1;
          errCode_d = 2'b10;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drivers. The start bit appears in the last inhibit cycle and is
  // held through REQ; the stop bit is a released line.
  always_comb begin
    serial_out = 1'b1;
    ndata_en   = 1'b1;
    nclk_en    = 1'b1;
    busy       = (state_q != IDLE);
    case (state_q)
      INHIBIT: begin
        nclk_en = 1'b0;
        if (inhLast) begin
          ndata_en   = 1'b0;
          serial_out = 1'b0;
        end
      end
      REQ: begin
        ndata_en   = 1'b0;
        serial_out = 1'b0;
      end
      SHIFT: begin
        if (bitCnt_q < BIT_W'(DATA_W)) begin
          ndata_en   = 1'b0;
          serial_out = shift_q[0];
        end else if ((PAR_EN != 0) && (bitCnt_q == BIT_W'(DATA_W))) begin
          ndata_en   = 1'b0;
          serial_out = parity_q;
        end
      end
      default: ;
    endcase
  end

  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign err_code = errCode_q;

endmodule

// File: tb/tb_kmi_transmit_p.sv
// tb_kmi_transmit_p
// Scoreboard bench for kmi_transmit_p. Four instances cover the default
// configuration, even parity, no parity and a 9-bit payload. A device model
// clocks the selected instance and reports every line sample; expected line
// bits and frame endings are queued when a frame is launched and popped by
// independent monitors.
module tb_kmi_transmit_p;

  localparam int TMO  = 4096;
  localparam int SYNC = 2;

  logic       refClk = 1'b0;
  logic       nreset;
  logic [3:0] transmitV;
  logic [3:0] clkInV;
  logic [3:0] serialInV;
  logic [8:0] dataIn;
  wire  [3:0] serialOutV, ndataEnV, nclkEnV, busyV, txDoneV, txErrV;
  wire  [7:0] errCodeV;

  logic [1:0] sel = 2'd0;
  logic       selSerialOut, selNdataEn, selNclkEn, selBusy, selTxDone, selTxErr;
  logic [1:0] selErrCode;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   endSeen = 0;
  int   endCycle = 0;
  int   lastFallCyc = 0;
  logic devSampleVal;
  event devSampleEv;

  logic       expBits[$];
  logic [3:0] expEnd[$];

  always #5 refClk = ~refClk;
  always @(posedge refClk) cyc++;

  kmi_transmit_p u0 (
    .ref_clk(refClk), .nreset(nreset), .transmit(transmitV[0]), .data_in(dataIn[7:0]),
    .clk_in(clkInV[0]), .serial_in(serialInV[0]), .serial_out(serialOutV[0]),
    .ndata_en(ndataEnV[0]), .nclk_en(nclkEnV[0]), .busy(busyV[0]),
    .tx_done(txDoneV[0]), .tx_err(txErrV[0]), .err_code(errCodeV[1:0]));

  kmi_transmit_p #(.PARITY_MODE(2)) u1 (
    .ref_clk(refClk), .nreset(nreset), .transmit(transmitV[1]), .data_in(dataIn[7:0]),
    .clk_in(clkInV[1]), .serial_in(serialInV[1]), .serial_out(serialOutV[1]),
    .ndata_en(ndataEnV[1]), .nclk_en(nclkEnV[1]), .busy(busyV[1]),
    .tx_done(txDoneV[1]), .tx_err(txErrV[1]), .err_code(errCodeV[3:2]));

  kmi_transmit_p #(.PARITY_MODE(0)) u2 (
    .ref_clk(refClk), .nreset(nreset), .transmit(transmitV[2]), .data_in(dataIn[7:0]),
    .clk_in(clkInV[2]), .serial_in(serialInV[2]), .serial_out(serialOutV[2]),
    .ndata_en(ndataEnV[2]), .nclk_en(nclkEnV[2]), .busy(busyV[2]),
    .tx_done(txDoneV[2]), .tx_err(txErrV[2]), .err_code(errCodeV[5:4]));

  kmi_transmit_p #(.DATA_W(9)) u3 (
    .ref_clk(refClk), .nreset(nreset), .transmit(transmitV[3]), .data_in(dataIn),
    .clk_in(clkInV[3]), .serial_in(serialInV[3]), .serial_out(serialOutV[3]),
    .ndata_en(ndataEnV[3]), .nclk_en(nclkEnV[3]), .busy(busyV[3]),
    .tx_done(txDoneV[3]), .tx_err(txErrV[3]), .err_code(errCodeV[7:6]));

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    selSerialOut = serialOutV[sel];
    selNdataEn   = ndataEnV[sel];
    selNclkEn    = nclkEnV[sel];
    selBusy      = busyV[sel];
    selTxDone    = txDoneV[sel];
    selTxErr     = txErrV[sel];
    selErrCode   = 2'(errCodeV >> {sel, 1'b0});
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Bit monitor: every bit the device samples is matched against the queue.
  always begin
    @(devSampleEv);
    if (expBits.size() == 0) begin
      failNow("unexpected line bit");
    end else begin
      checkOutput("line bit", 16'(devSampleVal), 16'(expBits.pop_front()));
    end
  end

  // End monitor: every done/err pulse is matched against the queue.
  always @(negedge refClk) begin
    if (nreset && (selTxDone || selTxErr)) begin
      endCycle = cyc;
      if (expEnd.size() == 0) begin
        checkOutput("unexpected end pulse", 16'({selTxDone, selTxErr, selErrCode}), 16'h0);
      end else begin
        checkOutput("end done/err/code", 16'({selTxDone, selTxErr, selErrCode}), 16'(expEnd.pop_front()));
      end
      checkOutput("busy at end", 16'(selBusy), 16'h0);
      checkOutput("lines released at end", 16'({selSerialOut, selNdataEn, selNclkEn}), 16'h7);
      endSeen++;
    end
  end

  // Launch a frame on instance idx; called at a negedge, transmit is high
  // for exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] idx, input logic [8:0] data,
                               input logic [15:0] bits, input int nBits,
                               input bit pushEnd, input logic [3:0] endCode);
    sel = idx;
    for (int i = 0; i < nBits; i++) expBits.push_back(bits[nBits-1-i]);
    if (pushEnd) expEnd.push_back(endCode);
    dataIn = data;
    transmitV[idx] = 1'b1;
    @(negedge refClk);
    transmitV[idx] = 1'b0;
    checkOutput("busy after accept", 16'(selBusy), 16'h1);
  endtask

  // Device model: waits for the request-to-send, then produces nFalls clock
  // periods, reporting the line value just before the first nSamples falls.
  task automatic runDevice(input int nFalls, input int nSamples, input bit ack);
    int waitCnt = 0;
    while (!(selNdataEn == 1'b0 && selNclkEn == 1'b1) && waitCnt < 400) begin
      @(negedge refClk);
      waitCnt++;
    end
    if (waitCnt >= 400) begin
      failNow("request phase wait");
      return;
    end
    for (int k = 1; k <= nFalls; k++) begin
      repeat (10) @(negedge refClk);
      if (k <= nSamples) begin
        devSampleVal = selNdataEn ? 1'b1 : selSerialOut;
        ->devSampleEv;
      end
      clkInV[sel] = 1'b0;
      lastFallCyc = cyc;
      if (ack && k == nFalls - 1) serialInV[sel] = 1'b0;
      repeat (10) @(negedge refClk);
      clkInV[sel] = 1'b1;
    end
    serialInV[sel] = 1'b1;
  endtask

  task automatic waitEnd(input int target, input int maxCycles);
    int n = 0;
    while (endSeen < target && n < maxCycles) begin
      @(negedge refClk);
      n++;
    end
    if (endSeen < target) failNow("end pulse wait");
    repeat (2) @(negedge refClk);
    checkOutput("bit queue drained", 16'(expBits.size()), 16'h0);
    checkOutput("end queue drained", 16'(expEnd.size()), 16'h0);
  endtask

  initial begin
    #1_000_000;
    failNow("global watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    nreset    = 1'b0;
    transmitV = '0;
    clkInV    = '1;
    serialInV = '1;
    dataIn    = '0;
    repeat (3) @(negedge refClk);
    checkOutput("reset lines", 16'({selSerialOut, selNdataEn, selNclkEn}), 16'h7);
    checkOutput("reset status", 16'({selBusy, selTxDone, selTxErr, selErrCode}), 16'h0);
    nreset = 1'b1;
    @(negedge refClk);

    // Defaults, 0xB3, odd parity 0, ACKed.
    target = endSeen + 1;
    applyStimulus(2'd0, 9'h0B3, 16'b01100110101, 11, 1'b1, 4'b1000);
    runDevice(12, 11, 1'b1);
    waitEnd(target, 200);

    // No ACK: error code 01 and the code is held in IDLE.
    target = endSeen + 1;
    applyStimulus(2'd0, 9'h0B3, 16'b01100110101, 11, 1'b1, 4'b0101);
    runDevice(12, 11, 1'b0);
    waitEnd(target, 200);
    checkOutput("err_code held", 16'(selErrCode), 16'h1);

    // Even parity, 0xB3 -> parity 1; the new frame clears err_code.
    target = endSeen + 1;
    applyStimulus(2'd1, 9'h0B3, 16'b01100110111, 11, 1'b1, 4'b1000);
    runDevice(12, 11, 1'b1);
    waitEnd(target, 200);

    // No parity, 0x00 -> ten line bits.
    target = endSeen + 1;
    applyStimulus(2'd2, 9'h000, 16'b0000000001, 10, 1'b1, 4'b1000);
    runDevice(11, 10, 1'b1);
    waitEnd(target, 200);

    // Nine-bit payload 0x1FF, odd parity 0.
    target = endSeen + 1;
    applyStimulus(2'd3, 9'h1FF, 16'b011111111101, 12, 1'b1, 4'b1000);
    runDevice(13, 12, 1'b1);
    waitEnd(target, 200);

    // Device stops clocking mid-frame: timeout after the last falling edge.
    target = endSeen + 1;
    applyStimulus(2'd0, 9'h0B3, 16'b0110, 4, 1'b1, 4'b0110);
    runDevice(4, 4, 1'b0);
    waitEnd(target, TMO + 200);
    checkOutput("timeout latency", 16'(endCycle - lastFallCyc), 16'(TMO + SYNC + 1));

    // Reset in the middle of SHIFT: immediate reset values, no pulse.
    target = endSeen;
    applyStimulus(2'd0, 9'h0B3, 16'b01100, 5, 1'b0, 4'b0000);
    runDevice(5, 5, 1'b0);
    checkOutput("busy mid-frame", 16'(selBusy), 16'h1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("async reset lines", 16'({selSerialOut, selNdataEn, selNclkEn}), 16'h7);
    checkOutput("async reset status", 16'({selBusy, selTxDone, selTxErr, selErrCode}), 16'h0);
    repeat (3) @(negedge refClk);
    nreset = 1'b1;
    checkOutput("no pulse on reset", 16'(endSeen), 16'(target));
    checkOutput("bit queue after reset", 16'(expBits.size()), 16'h0);

    // First cycle after release: a new frame is accepted and completes.
    target = endSeen + 1;
    applyStimulus(2'd0, 9'h0B3, 16'b01100110101, 11, 1'b1, 4'b1000);
    runDevice(12, 11, 1'b1);
    waitEnd(target, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
